datapath_ctrl: RTL

- Multicycle control unit for the 16-bit CPU datapath.
- Decodes the 32-bit instruction word and evaluates branch conditions against the registered ALU flags.
- Drives the datapath mux selects, PC-source select and register write enable.
- Sequences data-memory accesses through a req/ack handshake, stalling the PC until ack.

---
 rtl/datapath_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/datapath_ctrl.sv
// Multicycle control unit for the 16-bit CPU datapath: decode, branch evaluation, memory handshake.
// Optional memory-wait timeout fault is built only when MEM_TIMEOUT_EN is defined.
module datapath_ctrl #(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        c,
  input  logic        v,
  input  logic        n,
  input  logic        z,
  input  logic        mem_ack,
  output logic        regwrite,
  output logic        mb,
  output logic        md,
  output logic [2:0]  pcsrc,
  output logic        immsrc,
  output logic        pc_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT, S_FAULT} state_t;

  localparam logic [2:0] OP_ALU_R = 3'b000;
  localparam logic [2:0] OP_ALU_I = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_BR    = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_JR    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [2:0] PC_INC = 3'b000;
  localparam logic [2:0] PC_REL = 3'b010;
  localparam logic [2:0] PC_IMM = 3'b110;
  localparam logic [2:0] PC_ALU = 3'b111;

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > (1 << TIMEOUT_W)) begin : g_cfg_check
    $error("MEM_TIMEOUT must be between 1 and 2**TIMEOUT_W");
  end

  state_t     r_state;
  logic [2:0] w_op;
  logic [3:0] w_cond;
  logic       w_taken;
  logic       w_is_mem;
  logic       w_tmo;
  logic       w_unused;

  assign w_op     = instr[31:29];
  assign w_cond   = instr[23:20];
  assign w_is_mem = (w_op == OP_LOAD) || (w_op == OP_STORE);
  assign w_unused = ^{instr[28:24], instr[19:0]};

  function automatic logic cond_met(input logic [3:0] cond,
                                    input logic fc, input logic fv,
                                    input logic fn, input logic fz);
    case (cond)
      4'h0:    return fz;
      4'h1:    return !fz;
      4'h2:    return fc;
      4'h3:    return !fc;
      4'h4:    return fn;
      4'h5:    return !fn;
      4'h6:    return fv;
      4'h7:    return !fv;
      4'h8:    return fc && !fz;
      4'h9:    return !fc || fz;
      4'hA:    return fn == fv;
      4'hB:    return fn != fv;
      4'hC:    return !fz && (fn == fv);
      4'hD:    return fz || (fn != fv);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign w_taken = cond_met(w_cond, c, v, n, z);

`ifdef MEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;

  // Counter only runs while waiting; held at zero in RUN so each access starts fresh.
  always_ff @(posedge clk) begin
    if (reset || r_state != S_MEM_WAIT) r_cnt <= '0;
    else if (!mem_ack)                  r_cnt <= r_cnt + 1'b1;
  end

  assign w_tmo = (r_cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_is_mem)              r_state <= S_MEM_WAIT;
          else if (w_op == OP_HALT)  r_state <= S_HALT;
        end
        S_MEM_WAIT: begin
          if (mem_ack)    r_state <= S_RUN;
          else if (w_tmo) r_state <= S_FAULT;
        end
        default: r_state <= r_state;
      endcase
    end
  end

  // Outputs decode from state and the (externally held) instruction word.
  always_comb begin
    regwrite = 1'b0;
    mb       = 1'b0;
    md       = 1'b0;
    pcsrc    = PC_INC;
    immsrc   = 1'b0;
    pc_en    = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    if (!reset) begin
      case (r_state)
        S_RUN: begin
          case (w_op)
            OP_ALU_R: begin
              regwrite = 1'b1;
              pc_en    = 1'b1;
            end
            OP_ALU_I: begin
              mb       = 1'b1;
              regwrite = 1'b1;
              pc_en    = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
              mem_req = 1'b1;
              mem_we  = (w_op == OP_STORE);
              mb      = 1'b1;
            end
            OP_BR: begin
              pcsrc = w_taken ? PC_REL : PC_INC;
              pc_en = 1'b1;
            end
            OP_CALL: begin
              mb       = 1'b1;
              immsrc   = 1'b1;
              regwrite = 1'b1;
              pcsrc    = PC_IMM;
              pc_en    = 1'b1;
            end
            OP_JR: begin
              pcsrc = PC_ALU;
              pc_en = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM_WAIT: begin
          mem_req = 1'b1;
          mem_we  = (w_op == OP_STORE);
          mb      = 1'b1;
          if (mem_ack) begin
            pc_en = 1'b1;
            if (w_op == OP_LOAD) begin
              md       = 1'b1;
              regwrite = 1'b1;
            end
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b1;
`ifdef MEM_TIMEOUT_EN
          fault  = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule
